multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Multi-cycle control FSM for the RV32I datapath: sequences fetch/decode/execute/memory/writeback and drives all datapath selects.
//  Decodes the latched IR (inst_field) into Branch/BranchN/Jump/MemtoReg/ALUSrc_B/ImmSel/ALU_Control.
//  Gates the PC clock-enable, IR load, RegWrite and memory strobes so each instruction commits exactly once.
//  Handshakes with wait-state instruction/data memories.
// PARAMETERS
//  CNT_W  32  width of cycle_cnt and instret_cnt
// PORTS
//  clk          in   1   system clock; all state updates on posedge
//  rst          in   1   synchronous, active-high reset
//  inst_field   in   32  instruction held in IR
//  zero         in   1   ALU zero flag from datapath
//  imem_ready   in   1   instruction memory data valid this cycle
//  dmem_ready   in   1   data memory access complete this cycle
//  halt         in   1   hold in FETCH without issuing (debug)
//  imem_req     out  1   instruction fetch request
//  IR_we        out  1   load IR
//  dmem_req     out  1   data memory request
//  MemRW        out  1   1=store, 0=load (valid with dmem_req)
//  PC_we        out  1   PC clock enable (commit)
//  RegWrite     out  1   register file write enable
//  Branch       out  1   take PC+imm when zero=1
//  BranchN      out  1   take PC+imm when zero=0
//  Jump         out  2   0 seq/branch, 1 PC+imm (jal), 2 ALU result (jalr)
//  MemtoReg     out  2   0 ALU, 1 Data_in, 2 PC+4, 3 imm
//  ALUSrc_B     out  1   0 rs2, 1 imm
//  ImmSel       out  3   0 I, 1 S, 2 B, 3 J, 4 U
//  ALU_Control  out  4   0 ADD 1 SUB 2 AND 3 OR 4 XOR 5 SLT 6 SLTU 7 SLL 8 SRL 9 SRA
//  illegal      out  1   sticky: unsupported opcode reached DECODE
//  state        out  3   FSM state, for debug display
//  cycle_cnt    out  CNT_W  cycles since reset
//  instret_cnt  out  CNT_W  committed instructions (PC_we pulses)
// BEHAVIOUR
//  States: FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 TRAP=5.
//  Reset: state=FETCH; all outputs 0; counters 0. Reset wins in any state, mid-wait included; no commit that cycle.
//  FETCH: if halt, stay, imem_req=0. Else imem_req=1; on imem_ready assert IR_we, go to DECODE; else stay.
//  DECODE: 1 cycle. Unsupported opcode -> TRAP, illegal=1. Else -> EXEC.
//  EXEC: 1 cycle. Load/store -> MEM; all others -> WB.
//  MEM: dmem_req=1, MemRW=store. Hold until dmem_ready, then -> WB. Strobes stay stable while waiting.
//  WB: PC_we=1, RegWrite=1 unless store or branch; -> FETCH.
//  TRAP: absorbing until rst; all strobes 0.
//  Selects are decoded combinationally from inst_field in DECODE, EXEC, MEM and WB; they are 0 in FETCH and TRAP.
//  Strobes (PC_we, RegWrite, IR_we, dmem_req) never assert outside their state.
//  Decode:
//   R:    ALUSrc_B=0, MemtoReg=0, ALU op from funct3/funct7.
//   I-ALU: ALUSrc_B=1, ImmSel=I.
//   lw:   ADD, MemtoReg=1.
//   sw:   ADD, ImmSel=S.
//   lui:  MemtoReg=3, ImmSel=U.
//   jal:  Jump=1, MemtoReg=2, ImmSel=J.
//   jalr: Jump=2, ALUSrc_B=1, ADD, MemtoReg=2.
//  Branches use ImmSel=B, ALUSrc_B=0:
//   beq:  SUB, Branch.
//   bne:  SUB, BranchN.
//   blt:  SLT, BranchN.
//   bge:  SLT, Branch.
//   bltu: SLTU, BranchN.
//   bgeu: SLTU, Branch.
//  Latency with zero wait states: 4 cycles (FETCH..WB) for non-memory instructions, 5 for lw/sw. Each ready-low cycle adds one.
//  cycle_cnt increments every non-reset cycle. instret_cnt increments on PC_we. Both wrap modulo 2^CNT_W.
// TESTING
//  1. Run 0x00500093 (addi x1,x0,5), ready always 1 -> states 0,1,2,4; WB: RegWrite=1, PC_we=1, ALUSrc_B=1, ALU_Control=0; instret=1 after 4 cycles.
//  2. Run 0x00002103 (lw x2,0(x0)), dmem_ready low 3 cycles -> MEM held 4 cycles, dmem_req=1, MemRW=0; WB MemtoReg=1; 8 cycles total.
//  3. Run 0x00102223 (sw x1,4(x0)) -> MEM MemRW=1, ImmSel=1; WB RegWrite=0, PC_we=1.
//  4. Run 0x00000463 (beq x0,x0,8) -> Branch=1, ALU_Control=1, ImmSel=2, RegWrite=0.
//     Run 0x008000EF (jal x1,8) -> Jump=1, MemtoReg=2, RegWrite=1.
//  5. Run 0x00000000 -> DECODE->TRAP, illegal=1, no PC_we. Only rst clears it.
//     halt=1 -> FETCH held, imem_req=0.
//  6. Assert rst in MEM while waiting -> next cycle state=0, all outputs 0, counters 0, no PC_we or RegWrite pulse.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Instruction/data memory handshake between the multi-cycle controller and its
// wait-state memories.
interface multicycle_ctrl_if;
    logic imem_req;
    logic imem_ready;
    logic dmem_req;
    logic dmem_ready;
    logic MemRW;

    modport master (
        output imem_req,
        output dmem_req,
        output MemRW,
        input  imem_ready,
        input  dmem_ready
    );

    modport slave (
        input  imem_req,
        input  dmem_req,
        input  MemRW,
        output imem_ready,
        output dmem_ready
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing, datapath
// select decode from the latched IR, commit gating and cycle/instret counters.
module multicycle_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        inst_field,
    input  logic               zero,
    input  logic               halt,
    multicycle_ctrl_if.master  mem,
    output logic               IR_we,
    output logic               PC_we,
    output logic               RegWrite,
    output logic               Branch,
    output logic               BranchN,
    output logic [1:0]         Jump,
    output logic [1:0]         MemtoReg,
    output logic               ALUSrc_B,
    output logic [2:0]         ImmSel,
    output logic [3:0]         ALU_Control,
    output logic               illegal,
    output logic [2:0]         state,
    output logic [CNT_W-1:0]   cycle_cnt,
    output logic [CNT_W-1:0]   instret_cnt
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3,
        ALU_XOR = 4'd4, ALU_SLT = 4'd5, ALU_SLTU = 4'd6, ALU_SLL = 4'd7,
        ALU_SRL = 4'd8, ALU_SRA = 4'd9
    } alu_e;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;

    state_e             state_q, state_d;
    logic               illegal_q, illegal_d;
    logic [CNT_W-1:0]   cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0]   instret_cnt_q, instret_cnt_d;

    logic [2:0]  f3;
    alu_e        alu_arith, dec_alu;
    logic        dec_br, dec_brn, dec_asrc, dec_legal, dec_mem, dec_store, dec_nowb;
    logic [1:0]  dec_jmp, dec_m2r;
    logic [2:0]  dec_imm;
    logic        sel_en;
    logic        imem_req_c, ir_we_c, dmem_req_c, memrw_c, pc_we_c, regwrite_c;
    logic        unused_bits;

    assign f3 = inst_field[14:12];
    // Branch compare is resolved in the datapath; only the select lines leave here.
    assign unused_bits = ^{zero, inst_field[31], inst_field[29:15], inst_field[11:7]};

    // funct7[5] only distinguishes SUB (R-type) and SRA (both R and I).
    always_comb begin
        alu_arith = ALU_ADD;
        case (f3)
            3'd0: alu_arith = (inst_field[30] && inst_field[6:0] == OP_R) ? ALU_SUB : ALU_ADD;
            3'd1: alu_arith = ALU_SLL;
            3'd2: alu_arith = ALU_SLT;
            3'd3: alu_arith = ALU_SLTU;
            3'd4: alu_arith = ALU_XOR;
            3'd5: alu_arith = inst_field[30] ? ALU_SRA : ALU_SRL;
            3'd6: alu_arith = ALU_OR;
            default: alu_arith = ALU_AND;
        endcase
    end

    always_comb begin
        dec_alu = ALU_ADD;  dec_br = 1'b0;  dec_brn = 1'b0;  dec_jmp = '0;
        dec_m2r = '0;  dec_asrc = 1'b0;  dec_imm = '0;  dec_legal = 1'b1;
        dec_mem = 1'b0;  dec_store = 1'b0;  dec_nowb = 1'b0;
        case (inst_field[6:0])
            OP_R:     dec_alu = alu_arith;
            OP_I:     begin dec_alu = alu_arith; dec_asrc = 1'b1; end
            OP_LOAD:  begin dec_mem = 1'b1; dec_asrc = 1'b1; dec_m2r = 2'd1; end
            OP_STORE: begin
                dec_mem = 1'b1; dec_store = 1'b1; dec_nowb = 1'b1;
                dec_asrc = 1'b1; dec_imm = 3'd1;
            end
            OP_LUI:   begin dec_m2r = 2'd3; dec_imm = 3'd4; end
            OP_JAL:   begin dec_jmp = 2'd1; dec_m2r = 2'd2; dec_imm = 3'd3; end
            OP_JALR:  begin dec_jmp = 2'd2; dec_asrc = 1'b1; dec_m2r = 2'd2; end
            OP_BR: begin
                dec_imm  = 3'd2;
                dec_nowb = 1'b1;
                dec_alu  = f3[2] ? (f3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
                // beq/bge/bgeu take on zero; bne/blt/bltu take on non-zero.
                dec_br   = (f3 == 3'd0) || (f3[2] && f3[0]);
                dec_brn  = !dec_br;
            end
            default:  dec_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        illegal_d     = illegal_q;
        imem_req_c    = 1'b0;
        ir_we_c       = 1'b0;
        dmem_req_c    = 1'b0;
        memrw_c       = 1'b0;
        pc_we_c       = 1'b0;
        regwrite_c    = 1'b0;
        case (state_q)
            S_FETCH: if (!halt) begin
                imem_req_c = 1'b1;
                if (mem.imem_ready) begin
                    ir_we_c = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (dec_legal) state_d = S_EXEC;
                else begin
                    state_d   = S_TRAP;
                    illegal_d = 1'b1;
                end
            end
            S_EXEC: state_d = dec_mem ? S_MEM : S_WB;
            S_MEM: begin
                dmem_req_c = 1'b1;
                memrw_c    = dec_store;
                if (mem.dmem_ready) state_d = S_WB;
            end
            S_WB: begin
                pc_we_c    = 1'b1;
                regwrite_c = !dec_nowb;
                state_d    = S_FETCH;
            end
            default: state_d = S_TRAP;
        endcase
        // A reset cycle must not launch a fetch, memory access or commit.
        if (rst) begin
            imem_req_c = 1'b0;  ir_we_c = 1'b0;  dmem_req_c = 1'b0;
            memrw_c    = 1'b0;  pc_we_c = 1'b0;  regwrite_c = 1'b0;
        end
        cycle_cnt_d   = cycle_cnt_q + CNT_W'(1);
        instret_cnt_d = instret_cnt_q + CNT_W'(pc_we_c);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_FETCH;
            illegal_q     <= 1'b0;
            cycle_cnt_q   <= '0;
            instret_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            illegal_q     <= illegal_d;
            cycle_cnt_q   <= cycle_cnt_d;
            instret_cnt_q <= instret_cnt_d;
        end
    end

    assign sel_en = !rst && (state_q inside {S_DECODE, S_EXEC, S_MEM, S_WB});

    always_comb begin
        Branch      = sel_en & dec_br;
        BranchN     = sel_en & dec_brn;
        Jump        = sel_en ? dec_jmp : '0;
        MemtoReg    = sel_en ? dec_m2r : '0;
        ALUSrc_B    = sel_en & dec_asrc;
        ImmSel      = sel_en ? dec_imm : '0;
        ALU_Control = sel_en ? dec_alu : ALU_ADD;
    end

    assign mem.imem_req = imem_req_c;
    assign mem.dmem_req = dmem_req_c;
    assign mem.MemRW    = memrw_c;
    assign IR_we        = ir_we_c;
    assign PC_we        = pc_we_c;
    assign RegWrite     = regwrite_c;
    assign illegal      = illegal_q;
    assign state        = state_q;
    assign cycle_cnt    = cycle_cnt_q;
    assign instret_cnt  = instret_cnt_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomised bench for multicycle_ctrl against an instruction-level model of
// phase sequence, decode table and counters.
module tb_multicycle_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, zero, halt;
    logic [31:0] inst_field;
    logic        IR_we, PC_we, RegWrite, Branch, BranchN, ALUSrc_B, illegal;
    logic [1:0]  Jump, MemtoReg;
    logic [2:0]  ImmSel, state;
    logic [3:0]  ALU_Control;
    logic [31:0] cycle_cnt, instret_cnt;

    multicycle_ctrl_if mif ();

    multicycle_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .inst_field(inst_field), .zero(zero), .halt(halt),
        .mem(mif), .IR_we(IR_we), .PC_we(PC_we), .RegWrite(RegWrite),
        .Branch(Branch), .BranchN(BranchN), .Jump(Jump), .MemtoReg(MemtoReg),
        .ALUSrc_B(ALUSrc_B), .ImmSel(ImmSel), .ALU_Control(ALU_Control),
        .illegal(illegal), .state(state), .cycle_cnt(cycle_cnt),
        .instret_cnt(instret_cnt)
    );

    typedef struct packed {
        logic       br, brn;
        logic [1:0] jmp, m2r;
        logic       asrc;
        logic [2:0] imm;
        logic [3:0] alu;
        logic       legal, is_mem, st, nowb;
    } dec_t;

    typedef struct {
        logic [23:0] outs;
        logic [31:0] cyc, ins;
        bit          pin;
        logic [31:0] pin_c, pin_i;
        logic        pin_ill;
    } exp_t;

    exp_t        exp_cur;
    bit          exp_valid = 0;
    dec_t        cur_dec;
    logic [31:0] m_cyc, m_ins;
    logic        m_ill;
    bit          pin_pend = 0;
    logic [31:0] pin_c, pin_i;
    logic        pin_ill;
    int          n_checks = 0, n_fail = 0;

    function automatic logic rb();
        return 1'($urandom_range(1, 0));
    endfunction

    // ALU op for register/immediate arithmetic, by funct3 with the funct7[5] variant.
    function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'd0: return alt ? 4'd1 : 4'd0;
            3'd1: return 4'd7;
            3'd2: return 4'd5;
            3'd3: return 4'd6;
            3'd4: return 4'd4;
            3'd5: return alt ? 4'd9 : 4'd8;
            3'd6: return 4'd3;
            default: return 4'd2;
        endcase
    endfunction

    function automatic dec_t decode(input logic [31:0] i);
        dec_t d;
        logic [2:0] f3;
        f3 = i[14:12];
        d = '0;
        d.legal = 1'b1;
        case (i[6:0])
            7'h33: d.alu = arith_op(f3, i[30]);
            7'h13: begin d.alu = arith_op(f3, f3 == 3'd5 && i[30]); d.asrc = 1'b1; end
            7'h03: begin d.is_mem = 1'b1; d.asrc = 1'b1; d.m2r = 2'd1; end
            7'h23: begin d.is_mem = 1'b1; d.st = 1'b1; d.nowb = 1'b1; d.asrc = 1'b1; d.imm = 3'd1; end
            7'h37: begin d.m2r = 2'd3; d.imm = 3'd4; end
            7'h6F: begin d.jmp = 2'd1; d.m2r = 2'd2; d.imm = 3'd3; end
            7'h67: begin d.jmp = 2'd2; d.asrc = 1'b1; d.m2r = 2'd2; end
            7'h63: begin
                d.imm = 3'd2; d.nowb = 1'b1;
                case (f3)
                    3'd0: begin d.alu = 4'd1; d.br  = 1'b1; end
                    3'd1: begin d.alu = 4'd1; d.brn = 1'b1; end
                    3'd4: begin d.alu = 4'd5; d.brn = 1'b1; end
                    3'd5: begin d.alu = 4'd5; d.br  = 1'b1; end
                    3'd6: begin d.alu = 4'd6; d.brn = 1'b1; end
                    default: begin d.alu = 4'd6; d.br = 1'b1; end
                endcase
            end
            default: d = '0;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] i;
        logic [2:0]  f3;
        int          k;
        i  = $urandom;
        k  = $urandom_range(0, 9);
        f3 = i[14:12];
        case (k)
            0: begin i[6:0] = 7'h33; i[31:25] = ((f3 == 3'd0 || f3 == 3'd5) && rb()) ? 7'h20 : 7'h00; end
            1: begin
                i[6:0] = 7'h13;
                if (f3 == 3'd1) i[31:25] = 7'h00;
                if (f3 == 3'd5) i[31:25] = rb() ? 7'h20 : 7'h00;
            end
            2: begin i[6:0] = 7'h03; i[14:12] = 3'd2; end
            3: begin i[6:0] = 7'h23; i[14:12] = 3'd2; end
            4: i[6:0] = 7'h37;
            5: i[6:0] = 7'h6F;
            6: begin i[6:0] = 7'h67; i[14:12] = 3'd0; end
            7, 8: begin i[6:0] = 7'h63; if (f3 == 3'd2 || f3 == 3'd3) i[14] = 1'b1; end
            default: case ($urandom_range(0, 3))
                0: i[6:0] = 7'h00;
                1: i[6:0] = 7'h17;
                2: i[6:0] = 7'h73;
                default: i[6:0] = 7'h0F;
            endcase
        endcase
        return i;
    endfunction

    task automatic set_pin(input logic [31:0] c, input logic [31:0] n, input logic ill);
        pin_pend = 1; pin_c = c; pin_i = n; pin_ill = ill;
    endtask

    // One clock cycle: drive inputs, publish expected outputs, advance the model.
    task automatic step(input logic [2:0] st, input logic ireq, input logic irwe,
                        input logic dreq, input logic mrw, input logic pcwe, input logic rw,
                        input logic h, input logic ir, input logic dr, input logic r);
        dec_t s;
        logic on;
        halt = h; mif.imem_ready = ir; mif.dmem_ready = dr; rst = r; zero = rb();
        on = !r && st >= 3'd1 && st <= 3'd4;
        s  = on ? cur_dec : '0;
        exp_cur.outs = {st, ireq & !r, irwe & !r, dreq & !r, mrw & !r, pcwe & !r, rw & !r,
                        s.br, s.brn, s.jmp, s.m2r, s.asrc, s.imm, s.alu, m_ill};
        exp_cur.cyc = m_cyc;  exp_cur.ins = m_ins;
        exp_cur.pin = pin_pend;  exp_cur.pin_c = pin_c;  exp_cur.pin_i = pin_i;
        exp_cur.pin_ill = pin_ill;
        pin_pend  = 0;
        exp_valid = 1;
        @(posedge clk); #1;
        if (r) begin m_cyc = '0; m_ins = '0; m_ill = 1'b0; end
        else begin m_cyc = m_cyc + 1; if (pcwe) m_ins = m_ins + 1; end
    endtask

    task automatic run_inst(input logic [31:0] i, input int nstall, input bit all_halt,
                            input int nwait, input int abort_at);
        logic h;
        inst_field = i;
        cur_dec = decode(i);
        for (int s = 0; s < nstall; s++) begin
            h = all_halt ? 1'b1 : rb();
            step(3'd0, !h, 0, 0, 0, 0, 0, h, h ? rb() : 1'b0, rb(), 0);
        end
        step(3'd0, 1, 1, 0, 0, 0, 0, 0, 1, rb(), 0);
        step(3'd1, 0, 0, 0, 0, 0, 0, rb(), rb(), rb(), 0);
        if (!cur_dec.legal) begin
            m_ill = 1'b1;
            repeat (3) step(3'd5, 0, 0, 0, 0, 0, 0, rb(), rb(), rb(), 0);
            set_pin(m_cyc, m_ins, 1'b1);
            step(3'd5, 0, 0, 0, 0, 0, 0, rb(), rb(), rb(), 1);
            set_pin(32'd0, 32'd0, 1'b0);
            return;
        end
        step(3'd2, 0, 0, 0, 0, 0, 0, rb(), rb(), rb(), 0);
        if (cur_dec.is_mem) begin
            for (int w = 0; w < nwait; w++) begin
                if (w == abort_at) begin
                    step(3'd3, 0, 0, 1, cur_dec.st, 0, 0, rb(), rb(), rb(), 1);
                    set_pin(32'd0, 32'd0, 1'b0);
                    return;
                end
                step(3'd3, 0, 0, 1, cur_dec.st, 0, 0, rb(), rb(), 0, 0);
            end
            step(3'd3, 0, 0, 1, cur_dec.st, 0, 0, rb(), rb(), 1, 0);
        end
        step(3'd4, 0, 0, 0, 0, 1, !cur_dec.nowb, rb(), rb(), rb(), 0);
    endtask

    always @(negedge clk) begin
        logic [23:0] act;
        act = {state, mif.imem_req, IR_we, mif.dmem_req, mif.MemRW, PC_we, RegWrite,
               Branch, BranchN, Jump, MemtoReg, ALUSrc_B, ImmSel, ALU_Control, illegal};
        if (exp_valid) begin
            n_checks++;
            if (act !== exp_cur.outs) begin
                n_fail++;
                $display("FAIL outputs t=%0t inst=%h: got %h expected %h", $time, inst_field, act, exp_cur.outs);
            end
            n_checks++;
            if (cycle_cnt !== exp_cur.cyc) begin
                n_fail++;
                $display("FAIL cycle_cnt t=%0t: got %0d expected %0d", $time, cycle_cnt, exp_cur.cyc);
            end
            n_checks++;
            if (instret_cnt !== exp_cur.ins) begin
                n_fail++;
                $display("FAIL instret_cnt t=%0t: got %0d expected %0d", $time, instret_cnt, exp_cur.ins);
            end
            if (exp_cur.pin) begin
                n_checks += 3;
                if (cycle_cnt !== exp_cur.pin_c) begin
                    n_fail++;
                    $display("FAIL pin cycle_cnt t=%0t: got %0d expected %0d", $time, cycle_cnt, exp_cur.pin_c);
                end
                if (instret_cnt !== exp_cur.pin_i) begin
                    n_fail++;
                    $display("FAIL pin instret_cnt t=%0t: got %0d expected %0d", $time, instret_cnt, exp_cur.pin_i);
                end
                if (illegal !== exp_cur.pin_ill) begin
                    n_fail++;
                    $display("FAIL pin illegal t=%0t: got %0b expected %0b", $time, illegal, exp_cur.pin_ill);
                end
            end
        end
    end

    initial begin
        int nw, ab;
        rst = 1'b1; halt = 1'b0; zero = 1'b0; inst_field = '0;
        mif.imem_ready = 1'b0; mif.dmem_ready = 1'b0;
        m_cyc = '0; m_ins = '0; m_ill = 1'b0;
        cur_dec = '0;
        repeat (2) @(posedge clk);
        #1;
        step(3'd0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);

        run_inst(32'h00500093, 0, 0, 0, -1);   // addi x1,x0,5
        set_pin(32'd4, 32'd1, 1'b0);
        run_inst(32'h00002103, 0, 0, 3, -1);   // lw x2,0(x0), 3 wait states
        set_pin(32'd12, 32'd2, 1'b0);
        run_inst(32'h00102223, 0, 0, 0, -1);   // sw x1,4(x0)
        set_pin(32'd17, 32'd3, 1'b0);
        run_inst(32'h00000463, 0, 0, 0, -1);   // beq x0,x0,8
        set_pin(32'd21, 32'd4, 1'b0);
        run_inst(32'h008000EF, 0, 0, 0, -1);   // jal x1,8
        set_pin(32'd25, 32'd5, 1'b0);
        run_inst(32'h00500093, 3, 1, 0, -1);   // halted three cycles in FETCH
        set_pin(32'd32, 32'd6, 1'b0);
        run_inst(32'h00002103, 0, 0, 3, 1);    // reset while MEM waits
        run_inst(32'h00000000, 0, 0, 0, -1);   // unsupported opcode traps

        repeat (150) begin
            nw = $urandom_range(0, 3);
            ab = (nw > 0 && $urandom_range(0, 9) == 0) ? $urandom_range(0, nw - 1) : -1;
            run_inst(rand_inst(), $urandom_range(0, 2), 0, nw, ab);
        end

        step(3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        exp_valid = 0;
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
